clock_pause_scheduler: RTL and testbench

CLOCK_PAUSE_SCHEDULER -- requirements
Module: clock_pause_scheduler

---
 rtl/io_clk_p.sv | 15 +
 rtl/rr_arbiter_2.sv | 18 +
 rtl/clock_pause_scheduler.sv | 144 ++++++++++++++
 tb/tb_clock_pause_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_clk_p.sv
// Shared types and default timeouts for the generated-clock pause scheduler.
package io_clk_p;

  typedef enum logic [2:0] {
    IDLE,
    LOCK,
    RUN,
    PAUSE,
    FAULT
  } state_t;

  localparam int unsigned DEF_LOCK_TIMEOUT  = 16;
  localparam int unsigned DEF_PAUSE_TIMEOUT = 4096;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: with both requesting, the one not granted last wins.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/clock_pause_scheduler.sv
// Sequences a clock generator through lock, run and arbitrated pause phases,
// with lock/pause timeouts reported on sticky error bits.
module clock_pause_scheduler
  import io_clk_p::*;
#(
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned PAUSE_TIMEOUT = DEF_PAUSE_TIMEOUT
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clk_en_i,
  input  logic       start_i,
  input  logic [1:0] req_valid_i,
  input  logic [1:0] req_long_i,
  output logic [1:0] req_ready_o,
  output logic [1:0] req_done_o,
  output logic       gen_enable_o,
  output logic       pause_enable_o,
  input  logic       gen_lock_i,
  input  logic       short_done_i,
  input  logic       long_done_i,
  output logic       running_o,
  output logic [1:0] err_o
);

  localparam int CNT_W = $clog2(PAUSE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LOCK_LIM  = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] PAUSE_LIM = CNT_W'(PAUSE_TIMEOUT);

  function automatic logic [1:0] onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  state_t           state;
  logic             ptr;
  logic             owner;
  logic             owner_long;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       grant;
  logic             accept;
  logic             done_hit;

  rr_arbiter_2 u_arb (
    .req   (req_valid_i),
    .last  (ptr),
    .grant (grant)
  );

  assign req_ready_o = (state == RUN && clk_en_i && start_i) ? grant : 2'b00;
  assign accept      = |(req_valid_i & req_ready_o);
  assign done_hit    = owner_long ? long_done_i : short_done_i;
  // Saturating increment so a stalled count can never wrap back under a limit.
  assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      ptr            <= 1'b1;
      owner          <= 1'b0;
      owner_long     <= 1'b0;
      cnt            <= '0;
      err_o          <= 2'b00;
      gen_enable_o   <= 1'b0;
      pause_enable_o <= 1'b0;
      running_o      <= 1'b0;
      req_done_o     <= 2'b00;
    end else begin
      req_done_o <= 2'b00;
      if (clk_en_i) begin
        case (state)
          IDLE: begin
            if (start_i) begin
              state        <= LOCK;
              cnt          <= '0;
              err_o        <= 2'b00;
              gen_enable_o <= 1'b1;
            end
          end
          LOCK: begin
            if (!start_i) begin
              state        <= IDLE;
              gen_enable_o <= 1'b0;
            end else if (gen_lock_i) begin
              state     <= RUN;
              running_o <= 1'b1;
            end else if (cnt_inc >= LOCK_LIM) begin
              state        <= FAULT;
              err_o[0]     <= 1'b1;
              gen_enable_o <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          RUN: begin
            if (!start_i) begin
              state        <= IDLE;
              gen_enable_o <= 1'b0;
              running_o    <= 1'b0;
            end else if (accept) begin
              state          <= PAUSE;
              owner          <= grant[1];
              owner_long     <= req_long_i[grant[1]];
              ptr            <= grant[1];
              cnt            <= '0;
              pause_enable_o <= 1'b1;
            end
          end
          PAUSE: begin
            if (!start_i) begin
              state          <= IDLE;
              gen_enable_o   <= 1'b0;
              pause_enable_o <= 1'b0;
              running_o      <= 1'b0;
              req_done_o     <= onehot(owner);
            end else if (done_hit) begin
              state          <= RUN;
              pause_enable_o <= 1'b0;
              req_done_o     <= onehot(owner);
            end else if (cnt_inc >= PAUSE_LIM) begin
              state          <= RUN;
              err_o[1]       <= 1'b1;
              pause_enable_o <= 1'b0;
              req_done_o     <= onehot(owner);
            end else begin
              cnt <= cnt_inc;
            end
          end
          FAULT: begin
            if (!start_i) state <= IDLE;
          end
          default: begin
            state          <= IDLE;
            gen_enable_o   <= 1'b0;
            pause_enable_o <= 1'b0;
            running_o      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_pause_scheduler.sv
// Randomized scenario bench for clock_pause_scheduler against a request-level model.
module tb_clock_pause_scheduler;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic       start;
  logic [1:0] req_valid;
  logic [1:0] req_long;
  logic [1:0] req_ready;
  logic [1:0] req_done;
  logic       gen_enable;
  logic       pause_enable;
  logic       gen_lock;
  logic       short_done;
  logic       long_done;
  logic       running;
  logic [1:0] err;

  int pass_cnt = 0;
  int total    = 0;
  bit last_owner;

  wire [4:0] outs = {gen_enable, pause_enable, running, req_done};

  clock_pause_scheduler dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .clk_en_i       (clk_en),
    .start_i        (start),
    .req_valid_i    (req_valid),
    .req_long_i     (req_long),
    .req_ready_o    (req_ready),
    .req_done_o     (req_done),
    .gen_enable_o   (gen_enable),
    .pause_enable_o (pause_enable),
    .gen_lock_i     (gen_lock),
    .short_done_i   (short_done),
    .long_done_i    (long_done),
    .running_o      (running),
    .err_o          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit winner(input logic [1:0] v);
    if (v == 2'b11) return ~last_owner;
    return v[1];
  endfunction

  function automatic logic [1:0] oh(input bit id);
    return id ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go_run();
    req_valid = 2'b00; clk_en = 1'b1; start = 1'b1; gen_lock = 1'b0;
    tick();
    gen_lock = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; clk_en = 1'b0; start = 1'b0; req_valid = 2'b00; req_long = 2'b00;
    gen_lock = 1'b0; short_done = 1'b0; long_done = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({outs, err, req_ready} !== 9'b0) $display("FAIL reset_outs got=%b want=%b", {outs, err, req_ready}, 9'b0);
    else pass_cnt++;
    last_owner = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clk_en = 1'b1;
    tick();
    total++;
    if ({outs, err} !== 7'b0) $display("FAIL idle_outs got=%b want=%b", {outs, err}, 7'b0);
    else pass_cnt++;
  endtask

  task automatic test_lock();
    int n;
    clk_en = 1'b1; start = 1'b1; gen_lock = 1'b0;
    tick();
    total++;
    if (outs !== 5'b10000) $display("FAIL lock_enter got=%b want=%b", outs, 5'b10000);
    else pass_cnt++;
    n = 0;
    for (int g = 0; g < 50 && n < 3; g++) begin
      clk_en = ($urandom % 3) != 0;
      tick();
      if (clk_en) n++;
    end
    clk_en = 1'b1; gen_lock = 1'b1;
    tick();
    total++;
    if ({outs, err} !== 7'b1010000) $display("FAIL lock_run got=%b want=%b", {outs, err}, 7'b1010000);
    else pass_cnt++;
    start = 1'b0; gen_lock = 1'b0;
    tick();
    total++;
    if (outs !== 5'b00000) $display("FAIL run_stop got=%b want=%b", outs, 5'b00000);
    else pass_cnt++;
  endtask

  task automatic test_lock_timeout();
    int n;
    clk_en = 1'b1; start = 1'b1; gen_lock = 1'b0;
    tick();
    n = 0;
    for (int g = 0; g < 200 && n < 16; g++) begin
      clk_en = ($urandom % 3) != 0;
      tick();
      if (clk_en) n++;
      if (n == 15 && clk_en) begin
        total++;
        if ({gen_enable, err} !== 3'b100) $display("FAIL lock_before_to got=%b want=%b", {gen_enable, err}, 3'b100);
        else pass_cnt++;
      end
    end
    clk_en = 1'b1;
    total++;
    if ({outs, err} !== 7'b0000001) $display("FAIL lock_timeout got=%b want=%b", {outs, err}, 7'b0000001);
    else pass_cnt++;
    gen_lock = 1'b1;
    repeat (3) tick();
    total++;
    if ({outs, err} !== 7'b0000001) $display("FAIL fault_hold got=%b want=%b", {outs, err}, 7'b0000001);
    else pass_cnt++;
    start = 1'b0;
    tick();
    start = 1'b1; gen_lock = 1'b0;
    tick();
    total++;
    if ({gen_enable, err} !== 3'b100) $display("FAIL err_clear got=%b want=%b", {gen_enable, err}, 3'b100);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    bit o;
    go_run();
    req_long = 2'b10; req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      o = winner(req_valid);
      total++;
      if (req_ready !== oh(o) || o !== k[0]) $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_ready, oh(k[0]));
      else pass_cnt++;
      tick();
      last_owner = o;
      total++;
      if (outs !== 5'b11100) $display("FAIL rr_pause got=%b want=%b", outs, 5'b11100);
      else pass_cnt++;
      if (o) short_done = 1'b1; else long_done = 1'b1;
      tick();
      short_done = 1'b0; long_done = 1'b0;
      total++;
      if (outs !== 5'b11100) $display("FAIL rr_ignore got=%b want=%b", outs, 5'b11100);
      else pass_cnt++;
      repeat ($urandom_range(0, 3)) tick();
      if (o) long_done = 1'b1; else short_done = 1'b1;
      tick();
      short_done = 1'b0; long_done = 1'b0;
      total++;
      if (outs !== {3'b101, oh(o)}) $display("FAIL rr_exit got=%b want=%b", outs, {3'b101, oh(o)});
      else pass_cnt++;
      if (k == 3) req_valid = 2'b00;
      #1;
    end
    tick();
    total++;
    if (outs !== 5'b10100) $display("FAIL rr_done_pulse got=%b want=%b", outs, 5'b10100);
    else pass_cnt++;
  endtask

  task automatic test_pause_timeout();
    go_run();
    req_valid = 2'b01; req_long = 2'b00;
    tick();
    last_owner = 1'b0;
    req_valid = 2'b00; long_done = 1'b1;
    tick();
    long_done = 1'b0;
    for (int i = 2; i <= 4096; i++) begin
      tick();
      if (i == 4095) begin
        total++;
        if ({outs, err} !== 7'b1110000) $display("FAIL pause_before_to got=%b want=%b", {outs, err}, 7'b1110000);
        else pass_cnt++;
      end
    end
    total++;
    if ({outs, err} !== 7'b1010110) $display("FAIL pause_timeout got=%b want=%b", {outs, err}, 7'b1010110);
    else pass_cnt++;
  endtask

  task automatic test_start_drop();
    req_valid = 2'b10; req_long = 2'b10;
    #1;
    total++;
    if (req_ready !== 2'b10) $display("FAIL lone_grant got=%b want=%b", req_ready, 2'b10);
    else pass_cnt++;
    tick();
    last_owner = 1'b1;
    req_valid = 2'b00; start = 1'b0;
    tick();
    total++;
    if ({outs, err} !== 7'b0001010) $display("FAIL drop_pause got=%b want=%b", {outs, err}, 7'b0001010);
    else pass_cnt++;
    tick();
    total++;
    if ({outs, err} !== 7'b0000010) $display("FAIL drop_idle got=%b want=%b", {outs, err}, 7'b0000010);
    else pass_cnt++;
    start = 1'b1;
    tick();
    total++;
    if (err !== 2'b00) $display("FAIL err_clear2 got=%b want=%b", err, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [1:0] v;
    logic [1:0] lg;
    bit o;
    bit is_long;
    bit hit;
    bit exited;
    go_run();
    for (int it = 0; it < 20; it++) begin
      v = 2'($urandom_range(1, 3)); lg = 2'($urandom_range(0, 3));
      req_valid = v; req_long = lg; clk_en = 1'b0;
      #1;
      total++;
      if (req_ready !== 2'b00) $display("FAIL rnd_gate got=%b want=%b", req_ready, 2'b00);
      else pass_cnt++;
      clk_en = 1'b1;
      #1;
      o = winner(v);
      is_long = lg[o];
      total++;
      if (req_ready !== oh(o)) $display("FAIL rnd_grant it=%0d got=%b want=%b", it, req_ready, oh(o));
      else pass_cnt++;
      tick();
      last_owner = o;
      req_valid = 2'b00;
      total++;
      if (outs !== 5'b11100) $display("FAIL rnd_pause got=%b want=%b", outs, 5'b11100);
      else pass_cnt++;
      exited = 1'b0;
      for (int c = 0; c < 60 && !exited; c++) begin
        clk_en = ($urandom % 4) != 0;
        short_done = ($urandom % 3) == 0;
        long_done = ($urandom % 3) == 0;
        if (c == 59) begin
          clk_en = 1'b1;
          if (is_long) long_done = 1'b1; else short_done = 1'b1;
        end
        hit = clk_en && (is_long ? long_done : short_done);
        tick();
        short_done = 1'b0; long_done = 1'b0;
        total++;
        if (hit) begin
          exited = 1'b1;
          if (outs !== {3'b101, oh(o)}) $display("FAIL rnd_exit got=%b want=%b", outs, {3'b101, oh(o)});
          else pass_cnt++;
        end else begin
          if (outs !== 5'b11100) $display("FAIL rnd_hold got=%b want=%b", outs, 5'b11100);
          else pass_cnt++;
        end
      end
      clk_en = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    go_run();
    req_valid = 2'b11; req_long = 2'b01;
    tick();
    req_valid = 2'b00; clk_en = 1'b0;
    total++;
    if (outs !== 5'b11100) $display("FAIL ar_pause got=%b want=%b", outs, 5'b11100);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({outs, err, req_ready} !== 9'b0) $display("FAIL async_reset got=%b want=%b", {outs, err, req_ready}, 9'b0);
    else pass_cnt++;
    last_owner = 1'b1;
    tick();
    rst_n = 1'b1;
    go_run();
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL ptr_reset got=%b want=%b", req_ready, 2'b01);
    else pass_cnt++;
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_lock_timeout();
    test_round_robin();
    test_pause_timeout();
    test_start_drop();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
